// File: rtl/iob_sync_hs_rx_pkg.sv
// rtl/iob_sync_hs_rx_pkg.sv - shared state encodings and counter width for the toggle handshake receiver
package iob_sync_hs_rx_pkg;

    localparam int SETTLE_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } hs_state_e;

endpackage

// File: rtl/iob_sync.sv
// rtl/iob_sync.sv - two-flop synchronizer with clock enable and asynchronous active-high reset
module iob_sync #(
    parameter int                 DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] meta_q;
    logic [DATA_W-1:0] sync_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else if (en_i) begin
            meta_q <= data_i;
            sync_q <= meta_q;
        end
    end

    assign data_o = sync_q;

endmodule

// File: rtl/iob_sync_hs_rx.sv
// rtl/iob_sync_hs_rx.sv - receive side of a two-phase req/ack handshake moving a word into clk_i
module iob_sync_hs_rx
    import iob_sync_hs_rx_pkg::*;
#(
    parameter int          DATA_W  = 8,
    parameter int unsigned RST_VAL = 0,
    parameter int          SETTLE  = 0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              req_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              proto_err_o
);

    localparam logic [DATA_W-1:0]       RST_DATA    = DATA_W'(RST_VAL);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

    hs_state_e             state_q, state_d;
    logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ack_q, ack_d;
    logic                  req_last_q, req_last_d;
    logic                  req_prev_q;
    logic                  proto_q, proto_d;
    logic                  req_sync;
    logic                  pending;

    iob_sync #(
        .DATA_W  (1),
        .RST_VAL (1'b0)
    ) u_req_sync (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (cke_i),
        .data_i (req_i),
        .data_o (req_sync)
    );

    assign pending = (req_sync != req_last_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ack_d      = ack_q;
        req_last_d = req_last_q;
        // Any request edge seen outside IDLE is a sender protocol violation
        proto_d    = proto_q | ((state_q != ST_IDLE) && (req_sync != req_prev_q));
        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    if (SETTLE == 0) begin
                        data_d  = data_i;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d   = SETTLE_LOAD;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    data_d  = data_i;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (ready_i) begin
                    valid_d    = 1'b0;
                    ack_d      = ~ack_q;
                    req_last_d = req_sync;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= RST_DATA;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            req_last_q <= 1'b0;
            req_prev_q <= 1'b0;
            proto_q    <= 1'b0;
        end else if (cke_i) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            req_last_q <= req_last_d;
            req_prev_q <= req_sync;
            proto_q    <= proto_d;
        end
    end

    assign ack_o       = ack_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign proto_err_o = proto_q;

endmodule
